decoder_pipe: RTL and testbench

//   Parametrised, registered binary-to-one-hot decoder with a valid/ready handshake on both sides.

---
 rtl/decoder_pkg.sv | 29 ++
 rtl/decoder_pipe_comb.sv | 36 +++
 rtl/decoder_pipe.sv | 134 +++++++++++++
 tb/tb_decoder_pipe.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
//   Shared constants and helpers for the registered one-hot decoder pipeline.
//   DEC_MAX_SEL_W bounds the select width every decoder in this slice may use.
//   onehot() decodes a maximum-width select into a maximum-width one-hot word.
//   Callers keep only the low (1 << SEL_W) bits of the result.
//   The FIFO entry struct is declared inside decoder_pipe.
//   A package typedef cannot follow the SEL_W parameter of a module.
// -----------------------------------------------------------------------------
package decoder_pkg;

   localparam int DEC_MAX_SEL_W = 6;
   localparam int DEC_MAX_OUT_W = 32'd1 << DEC_MAX_SEL_W;

   // One-hot decode of sel with enable; all-zero when en is low.
   function automatic logic [DEC_MAX_OUT_W-1:0] onehot(
      input logic [DEC_MAX_SEL_W-1:0] sel,
      input logic                     en
   );
      logic [DEC_MAX_OUT_W-1:0] one_s;
      one_s = {{(DEC_MAX_OUT_W-1){1'b0}}, 1'b1};
      if (en) begin
         onehot = one_s << sel;
      end else begin
         onehot = {DEC_MAX_OUT_W{1'b0}};
      end
   endfunction

endpackage

// File: rtl/decoder_pipe_comb.sv
// -----------------------------------------------------------------------------
// decoder_comb
//   Purely combinational SEL_W -> (1 << SEL_W) one-hot decoder with enable.
//   Ports:
//     sel_i  in  SEL_W   binary index
//     en_i   in  1       enable; 0 gives an all-zero result
//     y_o    out OUT_W   one-hot (or all-zero) decode
// -----------------------------------------------------------------------------
module decoder_comb
   import decoder_pkg::*;
#(
   parameter int SEL_W = 5
) (
   input  logic [SEL_W-1:0]            sel_i,
   input  logic                        en_i,
   output logic [(32'd1 << SEL_W)-1:0] y_o
);

   localparam int OUT_W = 32'd1 << SEL_W;

   logic [DEC_MAX_SEL_W-1:0] sel_ext_s;
   logic [DEC_MAX_OUT_W-1:0] y_full_s;
   logic                     unused_s;

   // Zero-extend the select to the package width, decode, keep the low OUT_W bits.
   always_comb begin
      sel_ext_s              = {DEC_MAX_SEL_W{1'b0}};
      sel_ext_s[SEL_W-1:0]   = sel_i;
      y_full_s               = onehot(sel_ext_s, en_i);
      y_o                    = y_full_s[OUT_W-1:0];
   end

   // The upper bits of the wide decode are zero whenever SEL_W is below the maximum.
   assign unused_s = ^y_full_s;

endmodule

// File: rtl/decoder_pipe.sv
// -----------------------------------------------------------------------------
// decoder_pipe
//   Registered binary-to-one-hot decoder feeding a 2-entry elastic FIFO.
//   There is a valid/ready handshake on the input side and on the output side.
//   The decode happens at push time and is stored, so y_o comes from storage flops.
//   y_o is gated to zero while the buffer is empty.
//   Configuration macro: DECODER_ZERO_MASK_EN
//     When defined, the stored y[0] is always 0 (x0 write suppression).
//     sel_o still echoes the select value.
//   Ports:
//     clk_i        in   1      clock, rising edge
//     rst_i        in   1      synchronous active-high reset
//     in_valid_i   in   1      request present on sel_i/en_i
//     in_ready_o   out  1      buffer has room this cycle
//     sel_i        in   SEL_W  index to decode
//     en_i         in   1      decode enable
//     out_valid_o  out  1      result present
//     out_ready_i  in   1      consumer takes result this cycle
//     y_o          out  OUT_W  one-hot result
//     sel_o        out  SEL_W  select that produced y_o
//     occ_o        out  2      occupancy 0..2
// -----------------------------------------------------------------------------
module decoder_pipe
   import decoder_pkg::*;
#(
   parameter int SEL_W = 5
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [SEL_W-1:0]            sel_i,
   input  logic                        en_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [(32'd1 << SEL_W)-1:0] y_o,
   output logic [SEL_W-1:0]            sel_o,
   output logic [1:0]                  occ_o
);

   localparam int OUT_W = 32'd1 << SEL_W;

   typedef struct packed {
      logic [SEL_W-1:0] sel;
      logic [OUT_W-1:0] y;
   } entry_t;

   entry_t           mem_q [2];
   entry_t           mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;

   logic [OUT_W-1:0] y_dec_s;
   entry_t           entry_new_s;
   logic             push_s;
   logic             pop_s;

   decoder_comb #(.SEL_W(SEL_W)) u_dec (
      .sel_i (sel_i),
      .en_i  (en_i),
      .y_o   (y_dec_s)
   );

   assign in_ready_o  = (count_q != 2'd2);
   assign out_valid_o = (count_q != 2'd0);
   assign occ_o       = count_q;
   assign push_s      = in_valid_i & in_ready_o;
   assign pop_s       = out_valid_o & out_ready_i;

   // Build the entry to store, applying the optional bit-0 mask.
   always_comb begin
      entry_new_s.sel = sel_i;
      entry_new_s.y   = y_dec_s;
`ifdef DECODER_ZERO_MASK_EN
      entry_new_s.y[0] = 1'b0;
`else
      entry_new_s.y[0] = y_dec_s[0];
`endif
   end

   // Next-state for storage, pointers and count.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = entry_new_s;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end else begin
         wr_ptr_d        = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous reset that flushes the buffer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '{sel: {SEL_W{1'b0}}, y: {OUT_W{1'b0}}};
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Present the head entry only while the buffer holds something.
   always_comb begin
      if (out_valid_o) begin
         y_o   = mem_q[rd_ptr_q].y;
         sel_o = mem_q[rd_ptr_q].sel;
      end else begin
         y_o   = {OUT_W{1'b0}};
         sel_o = {SEL_W{1'b0}};
      end
   end

endmodule

// File: tb/tb_decoder_pipe.sv
module tb_decoder_pipe;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [4:0]  sel_i;
   logic        en_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] y_o;
   logic [4:0]  sel_o;
   logic [1:0]  occ_o;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef DECODER_ZERO_MASK_EN
   localparam logic [31:0] Y_SEL0 = 32'h0000_0000;
`else
   localparam logic [31:0] Y_SEL0 = 32'h0000_0001;
`endif

   decoder_pipe #(.SEL_W(5)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .sel_i       (sel_i),
      .en_i        (en_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .y_o         (y_o),
      .sel_o       (sel_o),
      .occ_o       (occ_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [31:0] exp_y;
      rst_i = 1'b1; in_valid_i = 1'b0; sel_i = 5'd0; en_i = 1'b0; out_ready_i = 1'b0;
      tick(); tick();
      rst_i = 1'b0;
      tick();
      // 1: reset then idle
      check("rst_in_ready", in_ready_o, 1);
      check("rst_out_valid", out_valid_o, 0);
      check("rst_y", y_o, 0);
      check("rst_occ", occ_o, 0);
      check("rst_sel", sel_o, 0);

      // 2: single request, latency one cycle
      in_valid_i = 1'b1; sel_i = 5'd17; en_i = 1'b1; out_ready_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
      check("t2_y", y_o, 32'h0002_0000);
      check("t2_sel", sel_o, 17);
      check("t2_occ", occ_o, 1);
      check("t2_valid", out_valid_o, 1);
      tick();
      check("t2_pop_occ", occ_o, 0);
      check("t2_pop_valid", out_valid_o, 0);
      check("t2_pop_y", y_o, 0);

      // 3: fill to full, third request ignored, drain in order
      out_ready_i = 1'b0;
      in_valid_i = 1'b1; sel_i = 5'd3;
      tick();
      check("t3_occ1", occ_o, 1);
      check("t3_ready1", in_ready_o, 1);
      sel_i = 5'd9;
      tick();
      check("t3_occ2", occ_o, 2);
      check("t3_ready_full", in_ready_o, 0);
      check("t3_head", y_o, 32'h0000_0008);
      sel_i = 5'd20;
      tick();
      check("t3_ignored_occ", occ_o, 2);
      check("t3_ignored_head", y_o, 32'h0000_0008);
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      tick();
      check("t3_second_y", y_o, 32'h0000_0200);
      check("t3_second_sel", sel_o, 9);
      check("t3_second_occ", occ_o, 1);
      tick();
      check("t3_drained", out_valid_o, 0);

      // 4: enable low, then sel 0 pushed alongside a pop at count 1
      in_valid_i = 1'b1; sel_i = 5'd7; en_i = 1'b0;
      tick();
      check("t4_en0_y", y_o, 0);
      check("t4_en0_sel", sel_o, 7);
      check("t4_en0_valid", out_valid_o, 1);
      sel_i = 5'd0; en_i = 1'b1;
      tick();
      check("t4_sel0_y", y_o, Y_SEL0);
      check("t4_sel0_sel", sel_o, 0);
      check("t4_sel0_occ", occ_o, 1);
      in_valid_i = 1'b0;
      tick();
      check("t4_empty", occ_o, 0);

      // 5: stream sel 0..31 back to back
      for (int i = 0; i < 32; i++) begin
         in_valid_i = 1'b1; sel_i = i[4:0]; en_i = 1'b1; out_ready_i = 1'b1;
         tick();
         exp_y = (i == 0) ? Y_SEL0 : (32'd1 << i);
         check($sformatf("t5_y_%0d", i), y_o, exp_y);
         check($sformatf("t5_sel_%0d", i), sel_o, i);
         check($sformatf("t5_occ_%0d", i), occ_o, 1);
      end
      in_valid_i = 1'b0;
      tick();
      check("t5_end_occ", occ_o, 0);

      // 6: reset while full flushes everything
      out_ready_i = 1'b0; in_valid_i = 1'b1; en_i = 1'b1; sel_i = 5'd11;
      tick();
      sel_i = 5'd12;
      tick();
      check("t6_full", occ_o, 2);
      rst_i = 1'b1; sel_i = 5'd13;
      tick();
      rst_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      check("t6_rst_occ", occ_o, 0);
      check("t6_rst_valid", out_valid_o, 0);
      check("t6_rst_ready", in_ready_o, 1);
      check("t6_rst_y", y_o, 0);
      tick();
      check("t6_post_valid", out_valid_o, 0);
      check("t6_post_y", y_o, 0);
      check("t6_post_occ", occ_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
